gpio_button: RTL and testbench

- Memory-mapped input peripheral for PicoSoC on the iomem bus; the read side complementing the write-only LED GPIO.
- Samples N external button/switch pins, synchronises and debounces each one, and latches rising edges in sticky status bits.
- Returns register contents to the CPU with a registered iomem_ready/iomem_rdata response.
- The CPU clears status bits with write-1-to-clear.

---
 rtl/gpio_button_pkg.sv | 15 +
 rtl/gpio_debounce.sv | 41 ++++
 rtl/gpio_button.sv | 105 ++++++++++
 tb/tb_gpio_button.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_button_pkg.sv
// Shared constants and helpers for the gpio_button iomem peripheral.
package gpio_button_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] OFF_STATE = 2'd0;
  localparam logic [1:0] OFF_EDGE  = 2'd1;
  localparam logic [1:0] OFF_IRQEN = 2'd2;

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin two-flop synchroniser followed by a consecutive-stable-cycle debouncer.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == TERM) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign dout = r_stable;

endmodule

// File: rtl/gpio_button.sv
// Debounced button/switch input block on the PicoSoC iomem bus with sticky rising-edge status.
// Optional interrupt enable register and irq output when GPIO_BUTTON_IRQ_EN is defined.
module gpio_button
  import gpio_button_pkg::*;
#(
  parameter int          N_INPUTS        = 4,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [N_INPUTS-1:0] buttons
`ifdef GPIO_BUTTON_IRQ_EN
  ,
  output logic                irq
`endif
);

  logic [N_INPUTS-1:0] w_state;
  logic [N_INPUTS-1:0] w_clr;
  logic [DATA_W-1:0]   w_wmask32;
  logic [DATA_W-1:0]   w_rsel;
  logic [1:0]          w_off;
  logic                w_hit;
  logic                w_wr;
  logic                w_unused;

  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic [N_INPUTS-1:0] r_state_d;
  logic [N_INPUTS-1:0] r_edge;
`ifdef GPIO_BUTTON_IRQ_EN
  logic [N_INPUTS-1:0] r_irqen;
  logic                r_irq;
`endif

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_db
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (buttons[gi]),
      .dout (w_state[gi])
    );
  end

  // A request is only accepted while no response is outstanding.
  assign w_hit     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]) && !r_ready;
  assign w_wr      = w_hit && (|iomem_wstrb);
  assign w_off     = iomem_addr[3:2];
  assign w_wmask32 = iomem_wdata & lane_mask(iomem_wstrb);
  assign w_clr     = (w_wr && w_off == OFF_EDGE) ? w_wmask32[N_INPUTS-1:0] : '0;
  assign w_unused  = &{1'b0, iomem_addr[1:0], w_wmask32};

  always_comb begin
    w_rsel = '0;
    case (w_off)
      OFF_STATE: w_rsel[N_INPUTS-1:0] = w_state;
      OFF_EDGE:  w_rsel[N_INPUTS-1:0] = r_edge;
`ifdef GPIO_BUTTON_IRQ_EN
      OFF_IRQEN: w_rsel[N_INPUTS-1:0] = r_irqen;
`endif
      default:   w_rsel = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_state_d <= '0;
      r_edge    <= '0;
`ifdef GPIO_BUTTON_IRQ_EN
      r_irqen   <= '0;
      r_irq     <= 1'b0;
`endif
    end else begin
      r_ready   <= w_hit;
      r_rdata   <= w_hit ? w_rsel : '0;
      r_state_d <= w_state;
      // A fresh rising edge overrides a simultaneous clear of the same bit.
      r_edge    <= (r_edge & ~w_clr) | (w_state & ~r_state_d);
`ifdef GPIO_BUTTON_IRQ_EN
      if (w_wr && w_off == OFF_IRQEN) begin
        r_irqen <= (r_irqen & ~lane_mask(iomem_wstrb)) | w_wmask32[N_INPUTS-1:0];
      end
      r_irq <= |(r_edge & r_irqen);
`endif
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
`ifdef GPIO_BUTTON_IRQ_EN
  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_gpio_button.sv
// Randomised bench for gpio_button with a behavioural model checked every cycle.
module tb_gpio_button;

  localparam int          N    = 4;
  localparam int          DC   = 4;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [N-1:0] buttons;
`ifdef GPIO_BUTTON_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  gpio_button #(
    .N_INPUTS(N),
    .DEBOUNCE_CYCLES(DC),
    .BASE_ADDR(BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .buttons    (buttons)
`ifdef GPIO_BUTTON_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin seen two edges late; the debounced level flips once
  // the last DC synchronised samples all disagree with it.
  logic [N-1:0]  m_s1, m_s2, m_stable, m_stab_d, m_edge, m_irqen;
  logic [DC-1:0] m_hist [N];
  logic          m_ready, m_irq;
  logic [31:0]   m_rdata;
  int            edge_no, stable_f_edge, rise_cnt0;

  always @(posedge clk or posedge reset) begin
    logic [N-1:0]  ns;
    logic [DC-1:0] h;
    logic          hit, wr;
    logic [1:0]    off;
    logic [N-1:0]  sel, wmask, clr;
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_stab_d <= '0;
      m_edge <= '0; m_irqen <= '0; m_ready <= 1'b0; m_irq <= 1'b0;
      m_rdata <= '0; edge_no <= 0; stable_f_edge <= 0; rise_cnt0 <= 0;
      for (int p = 0; p < N; p++) m_hist[p] <= '0;
    end else begin
      ns = m_stable;
      for (int p = 0; p < N; p++) begin
        h = {m_hist[p][DC-2:0], m_s2[p]};
        m_hist[p] <= h;
        if (h == {DC{~m_stable[p]}}) ns[p] = ~m_stable[p];
      end
      m_s1     <= buttons;
      m_s2     <= m_s1;
      m_stable <= ns;
      m_stab_d <= m_stable;
      edge_no  <= edge_no + 1;
      if (ns == 4'hF && stable_f_edge == 0) stable_f_edge <= edge_no + 1;
      if (ns[0] && !m_stable[0]) rise_cnt0 <= rise_cnt0 + 1;

      hit = iomem_valid && (iomem_addr[31:4] == BASE[31:4]) && !m_ready;
      wr  = hit && (iomem_wstrb != 4'b0);
      off = iomem_addr[3:2];
      case (off)
        2'd0:    sel = m_stable;
        2'd1:    sel = m_edge;
`ifdef GPIO_BUTTON_IRQ_EN
        2'd2:    sel = m_irqen;
`endif
        default: sel = '0;
      endcase
      m_ready <= hit;
      m_rdata <= hit ? {28'b0, sel} : 32'b0;
      wmask = iomem_wdata[3:0] & {4{iomem_wstrb[0]}};
      clr   = (wr && off == 2'd1) ? wmask : '0;
      m_edge <= (m_edge & ~clr) | (m_stable & ~m_stab_d);
`ifdef GPIO_BUTTON_IRQ_EN
      if (wr && off == 2'd2) m_irqen <= (m_irqen & ~{4{iomem_wstrb[0]}}) | wmask;
      m_irq <= |(m_edge & m_irqen);
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
      chk("rdata", iomem_rdata, m_rdata);
`ifdef GPIO_BUTTON_IRQ_EN
      chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    end
  end

  // Called just after a negedge with no response outstanding; returns likewise.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    lat = 0;
    rd  = '0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (iomem_ready) begin
        lat = i;
        rd  = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    chk("xfer_latency", lat, 1);
    $display("xfer addr=%h wstrb=%b wdata=%h rdata=%h lat=%0d", addr, strb, wd, rd, lat);
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] off, output logic [31:0] rd);
    bus_xfer(BASE + {28'b0, off, 2'b00}, 4'b0, 32'b0, rd);
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] rd;
    bus_xfer(BASE + {28'b0, off, 2'b00}, strb, wd, rd);
  endtask

  initial begin
    logic [31:0] rd;
    int          r0;
    logic        found;
    reset = 1'b1;
    buttons = 4'hF;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0;
    iomem_addr  = 32'b0;
    iomem_wdata = 32'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, iomem_ready}, 32'd0);
    chk("reset_rdata", iomem_rdata, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Pins held high through reset: state appears on edge 6.
    rd_reg(2'd0, rd);            chk("state_early", rd, 32'h0);
    repeat (20) @(negedge clk);
    chk("model_stable_edge", stable_f_edge, 6);
    rd_reg(2'd0, rd);            chk("state_all", rd, 32'hF);
    rd_reg(2'd1, rd);            chk("edge_all", rd, 32'hF);
    wr_reg(2'd1, 4'b0001, 32'hF);
    rd_reg(2'd1, rd);            chk("edge_cleared", rd, 32'h0);

    // Bouncing pin 0: no change until it holds for DC cycles.
    buttons[0] = 1'b0;
    repeat (12) @(negedge clk);
    r0 = rise_cnt0;
    for (int i = 0; i < 10; i++) begin
      buttons[0] = ~buttons[0];
      repeat (2) @(negedge clk);
    end
    buttons[0] = 1'b1;
    repeat (12) @(negedge clk);
    chk("model_rises_pin0", rise_cnt0 - r0, 1);
    rd_reg(2'd0, rd);            chk("state_after_bounce", rd, 32'hF);
    rd_reg(2'd1, rd);            chk("edge_after_bounce", rd, 32'h1);

    buttons[2] = 1'b0; repeat (12) @(negedge clk);
    buttons[2] = 1'b1; repeat (12) @(negedge clk);
    rd_reg(2'd1, rd);            chk("edge_0x5", rd, 32'h5);
    wr_reg(2'd1, 4'b0001, 32'h1);
    rd_reg(2'd1, rd);            chk("edge_w1c", rd, 32'h4);

    // Clear of bit 2 on the very edge its rise is latched.
    buttons[2] = 1'b0; repeat (12) @(negedge clk);
    wr_reg(2'd1, 4'b0001, 32'h4);
    buttons[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (m_stable[2] && !m_stab_d[2]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("collision_found", {31'b0, found}, 32'd1);
    wr_reg(2'd1, 4'b0001, 32'h4);
    rd_reg(2'd1, rd);            chk("edge_set_wins", rd, 32'h4);

    // Non-matching address never answers.
    iomem_valid = 1'b1;
    iomem_addr  = BASE + 32'h100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("miss_ready", {31'b0, iomem_ready}, 32'd0);
      chk("miss_rdata", iomem_rdata, 32'd0);
    end
    iomem_valid = 1'b0;
    @(negedge clk);

    wr_reg(2'd0, 4'b1111, 32'h0);
    rd_reg(2'd0, rd);            chk("state_ro", rd, 32'hF);
    wr_reg(2'd3, 4'b1111, 32'hF);
    rd_reg(2'd3, rd);            chk("reserved", rd, 32'h0);

`ifdef GPIO_BUTTON_IRQ_EN
    wr_reg(2'd1, 4'b0001, 32'hF);
    wr_reg(2'd2, 4'b0001, 32'h2);
    rd_reg(2'd2, rd);            chk("irqen", rd, 32'h2);
    buttons[1] = 1'b0; repeat (12) @(negedge clk);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    buttons[1] = 1'b1; repeat (12) @(negedge clk);
    chk("irq_pin1", {31'b0, irq}, 32'd1);
    wr_reg(2'd1, 4'b0001, 32'h2);
    chk("irq_cleared", {31'b0, irq}, 32'd0);
    buttons[0] = 1'b0; repeat (12) @(negedge clk);
    buttons[0] = 1'b1; repeat (12) @(negedge clk);
    chk("irq_masked", {31'b0, irq}, 32'd0);
`else
    wr_reg(2'd2, 4'b1111, 32'hF);
    rd_reg(2'd2, rd);            chk("irqen_absent", rd, 32'h0);
`endif

    // Random phase: slow, bouncy pins with mixed bus traffic.
    for (int t = 0; t < 300; t++) begin
      int kind;
      logic [1:0] off;
      logic [3:0] strb;
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 5) == 0) buttons[p] = ~buttons[p];
      kind = $urandom_range(0, 9);
      off  = 2'($urandom_range(0, 3));
      strb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
      if (kind <= 5) begin
        bus_xfer(BASE + {28'b0, off, 2'b00}, strb, $urandom, rd);
      end else if (kind == 6) begin
        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h100 + {28'b0, off, 2'b00};
        iomem_wstrb = strb;
        iomem_wdata = $urandom;
        repeat (2) @(negedge clk);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
      end else if (kind == 7) begin
        iomem_valid = 1'b1;
        iomem_addr  = BASE + {28'b0, off, 2'b00};
        iomem_wstrb = 4'b0;
        repeat (5) @(negedge clk);
        iomem_valid = 1'b0;
        @(negedge clk);
      end else begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
